// File: rtl/dice_pkg.sv
// dice_pkg: shared types and constants for the dice roll sequencer
package dice_pkg;
   typedef enum logic [1:0] {IDLE, SPIN, SLOW, HOLD} state_t;
   localparam int FACE_W = 3;
   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/dice_roll_controller_tick_divider.sv
// tick_divider: counter that pulses tick when it reaches a programmable terminal value
module tick_divider #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         tick
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick = !clr && (cnt_q == term);
      cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dice_roll_controller.sv
// dice_roll_controller: turns a button level into a spin, a slowing roll and a held random face
module dice_roll_controller
   import dice_pkg::*;
#(
   parameter int                TICK_DIV   = 1000,
   parameter int                SLOW_STEPS = 4,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              roll,
   output logic [FACE_W-1:0] s,
   output logic              rolling,
   output logic              done
);
   localparam int CW = $clog2(TICK_DIV << SLOW_STEPS);
   state_t            state_q, state_d;
   logic [FACE_W-1:0] s_q, s_d, target_q, target_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [2:0]        stage_q, stage_d;
   logic              rolling_q, rolling_d, done_q, done_d;
   logic              roll_q, rise_q, rise_d, fall_q, fall_d;
   logic              clr, tick;
   logic [CW:0]       slow_len;
   logic [CW-1:0]     term;
   tick_divider #(.W(CW)) u_tick (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .term (term),
      .tick (tick)
   );
   // Edges are registered so the roll input never reaches an output combinationally.
   always_comb begin
      slow_len = (CW+1)'(TICK_DIV) << ({1'b0, stage_q} + 4'd1);
      term = (state_q == SLOW) ? CW'(slow_len - (CW+1)'(1)) : CW'(TICK_DIV - 1);
      lfsr_d = lfsr_next(lfsr_q);
      rise_d = roll & ~roll_q;
      fall_d = ~roll & roll_q;
      state_d = state_q;
      s_d = s_q;
      stage_d = stage_q;
      target_d = target_q;
      done_d = 1'b0;
      clr = 1'b0;
      case (state_q)
         SPIN: begin
            if (fall_q) begin
               target_d = lfsr_q[FACE_W-1:0];
               stage_d = '0;
               state_d = SLOW;
               clr = 1'b1;
            end else if (tick) s_d = s_q + FACE_W'(1);
         end
         SLOW: begin
            if (tick && stage_q == 3'(SLOW_STEPS - 1)) begin
               s_d = target_q;
               done_d = 1'b1;
               state_d = HOLD;
            end else if (tick) begin
               s_d = s_q + FACE_W'(1);
               stage_d = stage_q + 3'd1;
            end
         end
         default: begin
            clr = 1'b1;
            state_d = rise_q ? SPIN : state_q;
         end
      endcase
      rolling_d = (state_d == SPIN) || (state_d == SLOW);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         s_q       <= '0;
         target_q  <= '0;
         stage_q   <= '0;
         lfsr_q    <= LFSR_SEED;
         rolling_q <= 1'b0;
         done_q    <= 1'b0;
         roll_q    <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         target_q  <= target_d;
         stage_q   <= stage_d;
         lfsr_q    <= lfsr_d;
         rolling_q <= rolling_d;
         done_q    <= done_d;
         roll_q    <= roll;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end
   assign s = s_q;
   assign rolling = rolling_q;
   assign done = done_q;
endmodule

// File: tb/tb_dice_roll_controller.sv
// tb_dice_roll_controller: directed rolls checked every cycle against a time-based roll model
module tb_dice_roll_controller;
   localparam int TD = 2;
   localparam int SS = 2;
   logic       clk = 1'b0, reset = 1'b1, roll = 1'b0, reset1 = 1'b1, roll1 = 1'b0;
   logic [2:0] s, s1;
   logic       rolling, done, rolling1, done1;
   int         tests = 0, fails = 0, cyc_n = 0, done_cnt = 0, rel_cyc = 0;
   int         m_phase = 0, m_el = 0, m_s = 0, m_tgt = 0;
   bit         m_done = 0, m_r1 = 0, m_r2 = 0;
   logic [7:0] m_lfsr = 8'hA5;
   always #5 clk = ~clk;
   dice_roll_controller #(.TICK_DIV(TD), .SLOW_STEPS(SS), .LFSR_SEED(8'hA5)) u_dut (
      .clk(clk), .reset(reset), .roll(roll), .s(s), .rolling(rolling), .done(done)
   );
   dice_roll_controller #(.TICK_DIV(1), .SLOW_STEPS(SS), .LFSR_SEED(8'hA5)) u_dut1 (
      .clk(clk), .reset(reset1), .roll(roll1), .s(s1), .rolling(rolling1), .done(done1)
   );
   function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction
   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   // Phases: 0 idle, 1 spin, 2 slow, 3 hold; m_el counts edges since the phase began.
   // Button edges act one edge after roll_q sees them, so r1/r2 are the last two sampled levels.
   task automatic model_step();
      logic [7:0] l_old;
      bit rise, fall;
      if (reset) begin
         m_phase = 0; m_el = 0; m_s = 0; m_done = 0; m_lfsr = 8'hA5; m_r1 = 0; m_r2 = 0;
         return;
      end
      rise = m_r1 && !m_r2;
      fall = !m_r1 && m_r2;
      m_r2 = m_r1;
      m_r1 = roll;
      l_old = m_lfsr;
      m_lfsr = lfsr_nx(m_lfsr);
      m_done = 0;
      case (m_phase)
         1: if (fall) begin
               m_tgt = int'(l_old[2:0]); m_phase = 2; m_el = 0;
            end else begin
               m_el++;
               if (m_el % TD == 0) m_s = (m_s + 1) % 8;
            end
         2: begin
               m_el++;
               if (m_el == TD * ((1 << (SS + 1)) - 2)) begin
                  m_s = m_tgt; m_done = 1; m_phase = 3;
               end else
                  for (int k = 1; k < SS; k++) if (m_el == TD * ((1 << (k + 1)) - 2)) m_s = (m_s + 1) % 8;
            end
         default: if (rise) begin m_phase = 1; m_el = 0; end
      endcase
   endtask
   initial forever begin
      @(posedge clk);
      cyc_n++;
      model_step();
      @(negedge clk);
      chk("s", int'(s), m_s);
      chk("rolling", int'(rolling), int'(m_phase == 1 || m_phase == 2));
      chk("done", int'(done), int'(m_done));
      if (done) done_cnt++;
   end
   task automatic release_roll();
      roll = 1'b0;
      rel_cyc = cyc_n;
   endtask
   task automatic wait_done(input string nm, input int exp_lat);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(nm, cyc_n - rel_cyc, exp_lat);
      chk({nm, "_rolling"}, int'(rolling), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int base, n;
      logic [7:0] nx;
      cyc(3);
      chk("rst_s", int'(s), 0);
      chk("rst_rolling", int'(rolling), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_lfsr", int'(u_dut.lfsr_q), 'hA5);
      reset = 1'b0;
      cyc(20);
      chk("idle_s", int'(s), 0);
      roll = 1'b1;
      cyc(1);
      chk("rise_lat_rolling", int'(rolling), 0);
      cyc(1);
      chk("spin_rolling", int'(rolling), 1);
      chk("spin_s0", int'(s), 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(2);
         chk("spin_step", int'(s), k % 8);
      end
      cyc(1);
      base = done_cnt;
      release_roll();
      cyc(5);
      chk("slow_s_pre", int'(s), 1);
      cyc(1);
      chk("slow_s_step", int'(s), 2);
      wait_done("settle_lat", 14);
      cyc(4);
      chk("settle_done_once", done_cnt - base, 1);
      roll = 1'b1;
      cyc(19);
      base = done_cnt;
      release_roll();
      cyc(3); roll = 1'b1;
      cyc(1); roll = 1'b0;
      cyc(2); roll = 1'b1;
      cyc(1); roll = 1'b0;
      cyc(2); roll = 1'b1;
      cyc(1); roll = 1'b0;
      wait_done("toggle_lat", 14);
      cyc(4);
      chk("toggle_done_once", done_cnt - base, 1);
      chk("toggle_no_restart", int'(rolling), 0);
      roll = 1'b1;
      cyc(2);
      chk("face5_spin", int'(rolling), 1);
      n = 0;
      nx = lfsr_nx(m_lfsr);
      while (!((m_el % 2) == 1 && nx[2:0] == 3'd5) && n < 600) begin
         cyc(1);
         n++;
         nx = lfsr_nx(m_lfsr);
      end
      chk("face5_found", int'(n < 600), 1);
      release_roll();
      cyc(4);
      roll = 1'b1;
      wait_done("face5_lat", 14);
      chk("face5_final", int'(s), 5);
      cyc(6);
      chk("held_no_restart", int'(rolling), 0);
      chk("held_s", int'(s), 5);
      roll = 1'b0;
      cyc(3);
      roll = 1'b1;
      cyc(2);
      chk("restart_rolling", int'(rolling), 1);
      chk("restart_s", int'(s), 5);
      cyc(2);
      chk("restart_step", int'(s), 6);
      n = 0;
      while ((m_el % 2) != 1 && n < 10) begin
         cyc(1);
         n++;
      end
      release_roll();
      cyc(4);
      chk("midrst_in_slow", int'(rolling), 1);
      base = done_cnt;
      reset = 1'b1;
      cyc(1);
      chk("midrst_s", int'(s), 0);
      chk("midrst_rolling", int'(rolling), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_lfsr", int'(u_dut.lfsr_q), 'hA5);
      reset = 1'b0;
      cyc(15);
      chk("midrst_no_done", done_cnt - base, 0);
      chk("midrst_s_idle", int'(s), 0);
      reset1 = 1'b0;
      roll1 = 1'b1;
      cyc(2);
      chk("td1_rolling", int'(rolling1), 1);
      chk("td1_s0", int'(s1), 0);
      for (int k = 1; k <= 9; k++) begin
         cyc(1);
         chk("td1_step", int'(s1), k % 8);
      end
      chk("td1_done", int'(done1), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
